// File: rtl/dmem_lsu_ram_pkg.sv
// Shared constants and types for the data-memory load/store unit:
// funct3 codes, FSM encoding, access-direction constants and pipeline metadata.
package dmem_lsu_ram_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // Request attributes carried alongside the synchronous RAM read
   typedef struct packed {
      logic       load;
      logic       err;
      logic [2:0] f3;
      logic [1:0] off;
   } meta_t;

endpackage

// File: rtl/ram_bank_sp.sv
// Single-port word RAM built from four byte lanes with per-lane write enables
// and a registered (synchronous) read port. Read-during-write returns old data.
module ram_bank_sp #(
   parameter int WORDS = 16384,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      always_ff @(posedge clk) begin
         if (en) begin
            if (be[l]) lane_mem[addr] <= wdata[l*8 +: 8];
            rdata[l*8 +: 8] <= lane_mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_lsu_ram.sv
// RV32I data-memory LSU: clears the RAM after reset, then accepts one
// load/store per cycle and returns an in-order response RD_LAT cycles later.
module dmem_lsu_ram
   import dmem_lsu_ram_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MEM_BASE    = 32'h0000_0000,
   parameter int              DEPTH_BYTES = 65536,
   parameter int              RD_LAT      = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [2:0]      req_funct3,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int AW    = $clog2(WORDS);

   state_t          state, state_nx;
   logic [AW-1:0]   clr_idx, clr_nx;

   logic            accept, err, illegal, misal, in_range;
   logic [3:0]      be, ram_be;
   logic [AW-1:0]   idx, ram_addr;
   logic [XLEN-1:0] wlanes, ram_wdata, ram_q, shifted, rdata1;
   logic            ram_en, err1;
   meta_t           meta;
   logic [RD_LAT:1] vld_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_INIT;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      clr_nx    = clr_idx;
      req_ready = 1'b0;
      case (state)
         ST_INIT: begin
            clr_nx = clr_idx + 1'b1;
            if (clr_idx == AW'(WORDS - 1)) begin
               state_nx = ST_RUN;
               clr_nx   = '0;
            end
         end
         ST_RUN:  req_ready = 1'b1;
         default: state_nx = ST_INIT;
      endcase
   end

   assign accept = req_valid & req_ready;

   // Request decode: legality, alignment, range, lane enables and lane data
   always_comb begin
      case (req_funct3)
         F3_SB, F3_SH, F3_SW: illegal = 1'b0;
         F3_LBU, F3_LHU:      illegal = (req_we == OP_WRITE);
         default:             illegal = 1'b1;
      endcase
      misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      in_range = ({1'b0, req_addr} >= {1'b0, MEM_BASE}) &&
                 ({1'b0, req_addr} <  ({1'b0, MEM_BASE} + (XLEN+1)'(DEPTH_BYTES)));
      err = illegal | misal | ~in_range;
      case (req_funct3[1:0])
         2'b00:   be = 4'b0001 << req_addr[1:0];
         2'b01:   be = 4'b0011 << req_addr[1:0];
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      case (req_funct3[1:0])
         2'b00:   wlanes = {4{req_wdata[7:0]}};
         2'b01:   wlanes = {2{req_wdata[15:0]}};
         default: wlanes = req_wdata;
      endcase
      idx = AW'((req_addr - MEM_BASE) >> 2);
   end

   // The clear sweep owns the RAM port while in INIT
   always_comb begin
      ram_en    = accept;
      ram_be    = (accept && req_we == OP_WRITE && !err) ? be : 4'b0000;
      ram_addr  = idx;
      ram_wdata = wlanes;
      if (state == ST_INIT) begin
         ram_en    = 1'b1;
         ram_be    = 4'b1111;
         ram_addr  = clr_idx;
         ram_wdata = '0;
      end
   end

   ram_bank_sp #(.WORDS(WORDS), .AW(AW)) u_bank (
      .clk   (clk),
      .en    (ram_en),
      .be    (ram_be),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         meta     <= '0;
      end else begin
         vld_pipe[1] <= accept;
         for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
         meta <= '{load: (req_we == OP_READ), err: err, f3: req_funct3, off: req_addr[1:0]};
      end
   end

   always_comb begin
      shifted = ram_q >> {meta.off, 3'b000};
      rdata1  = '0;
      err1    = vld_pipe[1] & meta.err;
      if (vld_pipe[1] && meta.load && !meta.err) begin
         case (meta.f3)
            F3_LB:   rdata1 = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata1 = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata1 = shifted;
            F3_LBU:  rdata1 = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  rdata1 = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: rdata1 = '0;
         endcase
      end
   end

   if (RD_LAT == 1) begin : g_lat1
      assign rsp_valid = vld_pipe[1];
      assign rsp_rdata = rdata1;
      assign rsp_err   = err1;
   end else begin : g_dly
      logic [RD_LAT-1:1][XLEN-1:0] dat_q;
      logic [RD_LAT-1:1]           err_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dat_q <= '0;
            err_q <= '0;
         end else begin
            dat_q[1] <= rdata1;
            err_q[1] <= err1;
            for (int s = 2; s <= RD_LAT-1; s++) begin
               dat_q[s] <= dat_q[s-1];
               err_q[s] <= err_q[s-1];
            end
         end
      end

      assign rsp_valid = vld_pipe[RD_LAT];
      assign rsp_rdata = dat_q[RD_LAT-1];
      assign rsp_err   = err_q[RD_LAT-1];
   end

endmodule

// File: doc/dmem_lsu_ram.md
DMEM_LSU_RAM -- requirements
Module: dmem_lsu_ram

Interface
Parameters:
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is legal.
REQ-002 SHALL have parameter MEM_BASE, default 32'h0000_0000, meaning byte address of the first location.
REQ-003 SHALL have parameter DEPTH_BYTES, default 65536, meaning capacity in bytes; a power of two, at least 16.
REQ-004 SHALL have parameter RD_LAT, default 1, meaning request-to-response latency in cycles; legal values 1..4.
Ports:
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state on the rising edge.
REQ-006 SHALL have port rst  in  1  meaning reset; asynchronous and active-high.
REQ-007 SHALL have port req_valid  in  1  meaning a request is present.
REQ-008 SHALL have port req_ready  out  1  meaning a request is accepted this cycle when req_valid is also 1.
REQ-009 SHALL have port req_we  in  1  meaning 1 = store, 0 = load.
REQ-010 SHALL have port req_addr  in  XLEN  meaning byte address.
REQ-011 SHALL have port req_wdata  in  XLEN  meaning store data, right-aligned.
REQ-012 SHALL have port req_funct3  in  3  meaning the RV32I load/store funct3 code.
REQ-013 SHALL have port rsp_valid  out  1  meaning a response is present, as a one-cycle pulse per request.
REQ-014 SHALL have port rsp_rdata  out  XLEN  meaning load result after extension; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  meaning the request was misaligned, out of range or used an illegal funct3.

Function
REQ-016 Storage SHALL be DEPTH_BYTES/4 words of four byte lanes, little-endian: byte at addr offset k maps to bits [8k+7:8k].
REQ-017 FSM states SHALL be INIT and RUN; reset enters INIT; INIT leaves to RUN after the last word is cleared.
REQ-018 In INIT, the block SHALL clear one word per cycle from index 0 upward, so INIT lasts exactly DEPTH_BYTES/4 cycles, with req_ready=0.
REQ-019 In RUN, req_ready SHALL be 1 every cycle; one request accepted per cycle, fully pipelined.
REQ-020 Loads SHALL decode as: 000 LB and 001 LH sign-extend; 010 LW; 100 LBU and 101 LHU zero-extend; any other funct3 is illegal.
REQ-021 Stores SHALL decode as: 000 SB, 001 SH, 010 SW; any other funct3 is illegal.
REQ-022 An access whose funct3 selects halfword SHALL be misaligned when addr[0]=1.
REQ-023 An access whose funct3 selects word SHALL be misaligned when addr[1:0]!=0.
REQ-024 An access SHALL be out of range when addr < MEM_BASE or addr >= MEM_BASE+DEPTH_BYTES.
REQ-025 An erroneous store SHALL modify no byte; an erroneous load SHALL return rdata 0; both SHALL set rsp_err=1.
REQ-026 A legal store SHALL write only the addressed byte lanes at the accept edge.
REQ-027 Every accepted request, load or store, SHALL produce rsp_valid exactly RD_LAT cycles after the accept edge, in order.
REQ-028 A load accepted in the cycle after a store to the same bytes SHALL return the newly stored data (write-then-read ordering).
REQ-029 Outside response pulses, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-030 Asserting rst SHALL immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the FSM to INIT with the clear index at 0.
REQ-031 Responses in flight when rst asserts SHALL be discarded and never emitted.
REQ-032 Memory contents SHALL be 0 everywhere after INIT completes; reset mid-INIT restarts the clear from index 0.

Structure
REQ-033 The funct3 load/store codes (LB..LHU, SB/SH/SW), the FSM state encoding and the READ/WRITE enable constants SHALL live in the shared config include.
REQ-034 The byte-lane array SHALL be one sub-module, ram_bank_sp: single port, 4 byte-write enables, synchronous read; the response delay line and extension logic stay in dmem_lsu_ram.

Verification
REQ-035 Apply reset, then wait DEPTH_BYTES/4 cycles -> req_ready rises on exactly that cycle; an LW at 0x0 then returns 0x0000_0000 with rsp_err=0.
REQ-036 SW 0x8765_4321 at 0x10, then LB, LBU, LH, LHU at 0x11 / 0x12 -> LB(0x11)=0x0000_0043, LH(0x12)=0xFFFF_8765, LHU(0x12)=0x0000_8765.
REQ-037 SB 0xAA at 0x21 over a word of 0x1122_3344 at 0x20, then LW 0x20 issued the next cycle -> 0x1122_AA44.
REQ-038 SH at 0x23, LW at 0x22, an LW at MEM_BASE+DEPTH_BYTES, and funct3=011 -> each gives rsp_err=1 and rdata 0; memory is unchanged.
REQ-039 With RD_LAT=3, issue back-to-back requests for 8 cycles -> 8 in-order rsp_valid pulses, each 3 cycles after its accept.
REQ-040 Assert rst with 2 loads in flight -> no rsp_valid appears; INIT restarts and the memory reads back all zero.
